// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter built from a bank of JK cells, with J/K excitation exported.
// Define JK_COUNTER_SAT_EN to saturate at the count boundary instead of wrapping.
module jk_sync_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrap
);

`ifdef JK_COUNTER_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [WIDTH-1:0] tog;
    logic             ones_run;
    logic             zeros_run;
    logic             at_bound;

    // A bit toggles when every lower bit is at the carry (up) or borrow (down) value.
    always_comb begin
        tog       = '0;
        ones_run  = 1'b1;
        zeros_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i]    = up ? ones_run : zeros_run;
            ones_run  = ones_run & q[i];
            zeros_run = zeros_run & ~q[i];
        end
    end

    assign at_bound = up ? (q == '1) : (q == '0);
    assign tc       = en & ~load & at_bound;

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (load) begin
            j_vec = din;
            k_vec = ~din;
        end else if (en && !(SAT && tc)) begin
            j_vec = tog;
            k_vec = tog;
        end
    end

    // Each cell: 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= (j_vec & ~q) | (~k_vec & q);
            wrap <= tc & ~SAT;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter: the driver pushes per-cycle expectations, a negedge monitor pops and checks.
module tb_jk_sync_counter;
    localparam int W = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'h0;
    logic [3:0] q, qb, j_vec, k_vec;
    logic       tc, wrap;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_items = 0;

    jk_sync_counter #(.WIDTH(4), .RST_VAL(4'h5)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .q(q), .qb(qb), .j_vec(j_vec), .k_vec(k_vec), .tc(tc), .wrap(wrap)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int item, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s item %0d: got %h expected %h", name, item, act, req);
    endtask

    // Inputs change 1 ns after the rising edge; expectations describe the cycle that follows.
    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] d,
                         input logic [3:0] eq, input logic [3:0] ej, input logic [3:0] ek,
                         input logic etc, input logic ew);
        @(posedge clk);
        #1;
        rst = r; en = e; up = u; load = l; din = d;
        exp_q.push_back({eq, ej, ek, etc, ew});
        tag_q.push_back(n_items);
        n_items++;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check("q", t, q, e[13:10]);
            check("qb", t, qb, ~e[13:10]);
            check("j_vec", t, j_vec, e[9:6]);
            check("k_vec", t, k_vec, e[5:2]);
            check("tc", t, {3'b0, tc}, {3'b0, e[1]});
            check("wrap", t, {3'b0, wrap}, {3'b0, e[0]});
        end
    end

    initial begin
        //     rst  en   up   ld   din    q     j     k     tc   wrap
        drive(1'b1,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
`ifndef JK_COUNTER_SAT_EN
        // up count through the wrap
        drive(1'b0,1'b0,1'b0,1'b1,4'hE, 4'h5,4'hE,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hE,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hF,4'hF,4'hF,1'b1,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h0,4'h1,4'h1,1'b0,1'b1);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h1,4'h3,4'h3,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b1,4'h7, 4'h2,4'h7,4'h8,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h7,4'hF,4'hF,1'b0,1'b0);
        // down count through the wrap
        drive(1'b0,1'b1,1'b1,1'b1,4'h1, 4'h8,4'h1,4'hE,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h1,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h0,4'hF,4'hF,1'b1,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'hF,4'h1,4'h1,1'b0,1'b1);
        drive(1'b0,1'b0,1'b0,1'b1,4'h8, 4'hE,4'h8,4'h7,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h8,4'hF,4'hF,1'b0,1'b0);
        // load priority, and load at the boundary suppresses wrap
        drive(1'b0,1'b0,1'b0,1'b1,4'h3, 4'h7,4'h3,4'hC,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b1,4'hA, 4'h3,4'hA,4'h5,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b1,4'hF, 4'hA,4'hF,4'h0,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b1,4'h2, 4'hF,4'h2,4'hD,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h2,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h3,4'h1,4'h1,1'b0,1'b0);
        // async reset mid-count, then resume from RST_VAL
        drive(1'b0,1'b0,1'b0,1'b1,4'h9, 4'h2,4'h9,4'h6,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h9,4'h0,4'h0,1'b0,1'b0);
        drive(1'b1,1'b1,1'b1,1'b0,4'h0, 4'h5,4'h3,4'h3,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h5,4'h3,4'h3,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'h6,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h7,4'h0,4'h0,1'b0,1'b0);
        // reset in the cycle a wrap pulse would appear
        drive(1'b0,1'b0,1'b0,1'b1,4'hF, 4'h7,4'hF,4'h0,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hF,4'hF,4'hF,1'b1,1'b0);
        drive(1'b1,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'h5,4'h0,4'h0,1'b0,1'b0);
`else
        // saturating: up holds at F, down holds at 0
        drive(1'b0,1'b0,1'b0,1'b1,4'hD, 4'h5,4'hD,4'h2,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hD,4'h3,4'h3,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hE,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hF,4'h0,4'h0,1'b1,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hF,4'h0,4'h0,1'b1,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'hF,4'h1,4'h1,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'hE,4'h3,4'h3,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b1,4'h0, 4'hD,4'h0,4'hF,1'b0,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h0,4'h0,4'h0,1'b1,1'b0);
        drive(1'b0,1'b1,1'b0,1'b0,4'h0, 4'h0,4'h0,4'h0,1'b1,1'b0);
        drive(1'b0,1'b1,1'b1,1'b1,4'hF, 4'h0,4'hF,4'h0,1'b0,1'b0);
        drive(1'b0,1'b0,1'b0,1'b0,4'h0, 4'hF,4'h0,4'h0,1'b0,1'b0);
        drive(1'b0,1'b1,1'b1,1'b0,4'h0, 4'hF,4'h0,4'h0,1'b1,1'b0);
`endif
        // drain: the monitor pops the last entry on the next falling edge
        repeat (3) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
